// File: rtl/mp64_clkgate_ctrl.sv
// Per-domain clock-gating sequencer: idle detection, quiesce drain, gating and
// timed wake for NDOM independent domains. Runs on the ungated root clock.
`timescale 1ns/1ps
module mp64_clkgate_ctrl #(
  parameter int NDOM      = 4,
  parameter int IDLE_W    = 16,
  parameter int DRAIN_TMO = 64,
  parameter int WAKE_CYC  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_gate_en,
  input  logic [IDLE_W-1:0] cfg_idle_thresh,
  input  logic [NDOM-1:0]   cfg_force_on,
  input  logic [NDOM-1:0]   dom_busy,
  input  logic [NDOM-1:0]   dom_wake,
  input  logic [NDOM-1:0]   quiesce_ack,
  output logic [NDOM-1:0]   clk_en,
  output logic [NDOM-1:0]   quiesce_req,
  output logic [NDOM-1:0]   dom_ready,
  output logic [NDOM-1:0]   drain_tmo,
  output logic [2*NDOM-1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  // One down-counter per domain serves both the drain timeout and wake settle.
  localparam int TMR_MAX = ((DRAIN_TMO - 1) > WAKE_CYC) ? (DRAIN_TMO - 1) : WAKE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_TMO - 1);
  localparam logic [TMR_W-1:0] WAKE_LOAD  = TMR_W'(WAKE_CYC);

  logic [NDOM-1:0] allow;
  logic [NDOM-1:0] act;

  assign allow = {NDOM{cfg_gate_en & (|cfg_idle_thresh)}} & ~cfg_force_on;
  assign act   = dom_busy | dom_wake;

  // Handshake: quiesce_req is a level held from DRAIN through WAKE; quiesce_ack is
  // sampled only in DRAIN, where any activity or loss of permit overrides it.
  for (genvar i = 0; i < NDOM; i++) begin : g_dom
    state_e            state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              tmo_d;
    logic              en_q, req_q, rdy_q, tmo_q;

    always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      tmr_d   = tmr_q;
      tmo_d   = 1'b0;
      case (state_q)
        ST_RUN: begin
          if (act[i] || !allow[i]) begin
            idle_d = '0;
          end else if (idle_q >= cfg_idle_thresh) begin
            state_d = ST_DRAIN;
            tmr_d   = DRAIN_LOAD;
          end else if (idle_q != '1) begin
            idle_d = idle_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (act[i] || !allow[i]) begin
            state_d = ST_RUN;
            idle_d  = '0;
          end else if (quiesce_ack[i]) begin
            state_d = ST_GATED;
          end else if (tmr_q == '0) begin
            state_d = ST_RUN;
            idle_d  = '0;
            tmo_d   = 1'b1;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        ST_GATED: begin
          if (act[i] || !allow[i]) begin
            state_d = ST_WAKE;
            tmr_d   = WAKE_LOAD;
          end
        end
        ST_WAKE: begin
          if (tmr_q == '0) begin
            state_d = ST_RUN;
            idle_d  = '0;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    // Outputs are decoded from the next state so they change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_RUN;
        idle_q  <= '0;
        tmr_q   <= '0;
        en_q    <= 1'b1;
        req_q   <= 1'b0;
        rdy_q   <= 1'b1;
        tmo_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
        tmr_q   <= tmr_d;
        en_q    <= (state_d != ST_GATED);
        req_q   <= (state_d != ST_RUN);
        rdy_q   <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
        tmo_q   <= tmo_d;
      end
    end

    assign clk_en[i]          = en_q;
    assign quiesce_req[i]     = req_q;
    assign dom_ready[i]       = rdy_q;
    assign drain_tmo[i]       = tmo_q;
    assign dbg_state[2*i +: 2] = state_q;
  end

endmodule

// File: tb/tb_mp64_clkgate_ctrl.sv
// Bench for mp64_clkgate_ctrl: directed latency/priority scenarios plus random
// traffic, all checked every cycle against a behavioural per-domain model.
`timescale 1ns/1ps
module tb_mp64_clkgate_ctrl;

  localparam int NDOM      = 4;
  localparam int IDLE_W    = 16;
  localparam int DRAIN_TMO = 64;
  localparam int WAKE_CYC  = 4;
  localparam int EW        = 4 * NDOM;
  localparam int IDLE_MAX  = (1 << IDLE_W) - 1;
  localparam int P_RUN = 0, P_DRAIN = 1, P_GATED = 2, P_WAKE = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_gate_en;
  logic [IDLE_W-1:0] cfg_idle_thresh;
  logic [NDOM-1:0]   cfg_force_on, dom_busy, dom_wake, quiesce_ack;
  logic [NDOM-1:0]   clk_en, quiesce_req, dom_ready, drain_tmo;
  logic [2*NDOM-1:0] dbg_state;

  mp64_clkgate_ctrl #(
    .NDOM(NDOM), .IDLE_W(IDLE_W), .DRAIN_TMO(DRAIN_TMO), .WAKE_CYC(WAKE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_gate_en(cfg_gate_en), .cfg_idle_thresh(cfg_idle_thresh),
    .cfg_force_on(cfg_force_on), .dom_busy(dom_busy), .dom_wake(dom_wake),
    .quiesce_ack(quiesce_ack), .clk_en(clk_en), .quiesce_req(quiesce_req),
    .dom_ready(dom_ready), .drain_tmo(drain_tmo), .dbg_state(dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each domain is tracked as a phase plus elapsed-cycle counts that count up.
  int m_ph[NDOM];
  int m_idle[NDOM];
  int m_el[NDOM];
  bit m_tmo[NDOM];

  task automatic model_reset();
    for (int d = 0; d < NDOM; d++) begin
      m_ph[d] = P_RUN; m_idle[d] = 0; m_el[d] = 0; m_tmo[d] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit allow, act;
    for (int d = 0; d < NDOM; d++) begin
      allow = cfg_gate_en && !cfg_force_on[d] && (cfg_idle_thresh != 0);
      act   = dom_busy[d] || dom_wake[d];
      m_tmo[d] = 1'b0;
      case (m_ph[d])
        P_RUN: begin
          if (act || !allow) m_idle[d] = 0;
          else if (m_idle[d] >= int'(cfg_idle_thresh)) begin m_ph[d] = P_DRAIN; m_el[d] = 0; end
          else if (m_idle[d] < IDLE_MAX) m_idle[d]++;
        end
        P_DRAIN: begin
          if (act || !allow) begin m_ph[d] = P_RUN; m_idle[d] = 0; end
          else if (quiesce_ack[d]) m_ph[d] = P_GATED;
          else begin
            m_el[d]++;
            if (m_el[d] == DRAIN_TMO) begin m_ph[d] = P_RUN; m_idle[d] = 0; m_tmo[d] = 1'b1; end
          end
        end
        P_GATED: if (act || !allow) begin m_ph[d] = P_WAKE; m_el[d] = 0; end
        default: begin
          m_el[d]++;
          if (m_el[d] == WAKE_CYC + 1) begin m_ph[d] = P_RUN; m_idle[d] = 0; end
        end
      endcase
    end
  endtask

  function automatic logic [EW-1:0] model_outputs();
    logic [NDOM-1:0] en, req, rdy, tmo;
    for (int d = 0; d < NDOM; d++) begin
      en[d]  = (m_ph[d] != P_GATED);
      req[d] = (m_ph[d] != P_RUN);
      rdy[d] = (m_ph[d] == P_RUN) || (m_ph[d] == P_DRAIN);
      tmo[d] = m_tmo[d];
    end
    return {en, req, rdy, tmo};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v;

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
    exp_q.push_back(model_outputs());
  end

  always @(negedge rst_n) begin
    model_reset();
    exp_q.delete();
    exp_q.push_back(model_outputs());
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check("cycle_outputs", 32'({clk_en, quiesce_req, dom_ready, drain_tmo}), 32'(exp_v));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_req(input int d, input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (quiesce_req[d]) begin n = c; break; end
    end
  endtask

  task automatic wait_tmo(input int d, input int budget, output int n, output bit dropped);
    n = -1;
    dropped = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (!clk_en[d]) dropped = 1'b1;
      if (drain_tmo[d]) begin n = c; break; end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit dropped;
    logic [NDOM-1:0] seen;
    int busy_pct, wake_pct, ack_pct;

    cfg_gate_en = 1'b1; cfg_idle_thresh = 16'd10; cfg_force_on = '0;
    dom_busy = '1; dom_wake = '0; quiesce_ack = '0;
    ticks(3);
    check("reset_clk_en", clk_en, 4'hF);
    check("reset_dom_ready", dom_ready, 4'hF);
    check("reset_quiesce_req", quiesce_req, 4'h0);
    check("reset_drain_tmo", drain_tmo, 4'h0);
    check("reset_state", dbg_state, 8'h00);
    rst_n = 1'b1;
    ticks(2);

    // idle gating and wake on domain 0
    dom_busy[0] = 1'b0;
    wait_req(0, 100, n);
    check("idle_to_req", n, 11);
    ticks(2);
    quiesce_ack[0] = 1'b1;
    tick();
    check("ack_gates_clk", clk_en[0], 1'b0);
    check("gated_not_ready", dom_ready[0], 1'b0);
    ticks(3);
    dom_wake[0] = 1'b1;
    tick();
    check("wake_clk_en", clk_en[0], 1'b1);
    check("wake_not_ready", dom_ready[0], 1'b0);
    dom_wake[0] = 1'b0;
    ticks(4);
    check("wake_settling", dom_ready[0], 1'b0);
    tick();
    check("wake_ready", dom_ready[0], 1'b1);
    check("wake_req_drop", quiesce_req[0], 1'b0);
    wait_req(0, 100, n);
    check("regate_idle", n, 11);
    dom_busy[0] = 1'b1; quiesce_ack[0] = 1'b0;
    ticks(8);

    // drain timeout on domain 1
    dom_busy[1] = 1'b0;
    wait_req(1, 100, n);
    check("tmo_idle_to_req", n, 11);
    wait_tmo(1, 200, n, dropped);
    check("tmo_cycles", n, DRAIN_TMO);
    check("tmo_clk_en_held", dropped, 1'b0);
    check("tmo_back_to_run", quiesce_req[1], 1'b0);
    tick();
    check("tmo_one_cycle", drain_tmo[1], 1'b0);
    wait_req(1, 100, n);
    check("tmo_redrain", n, 10);
    dom_busy[1] = 1'b1;
    tick();
    check("busy_aborts_drain", quiesce_req[1], 1'b0);

    // busy and ack in the same cycle: abort wins
    dom_busy[2] = 1'b0;
    wait_req(2, 100, n);
    dom_busy[2] = 1'b1; quiesce_ack[2] = 1'b1;
    tick();
    check("race_req", quiesce_req[2], 1'b0);
    check("race_clk_en", clk_en[2], 1'b1);
    quiesce_ack[2] = 1'b0;

    // ack arriving on the timeout edge: ack wins
    dom_busy[3] = 1'b0;
    wait_req(3, 100, n);
    ticks(DRAIN_TMO - 1);
    quiesce_ack[3] = 1'b1;
    tick();
    check("tmo_ack_race_gated", clk_en[3], 1'b0);
    check("tmo_ack_race_pulse", drain_tmo[3], 1'b0);
    quiesce_ack[3] = 1'b0; dom_busy[3] = 1'b1;
    ticks(8);

    // configuration overrides
    cfg_idle_thresh = 16'd0; dom_busy = '0; quiesce_ack = '1;
    seen = '0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      seen = seen | quiesce_req | ~clk_en;
    end
    check("thresh0_never_gates", seen, 4'h0);
    cfg_idle_thresh = 16'd10; cfg_force_on = 4'b0101;
    seen = '0;
    for (int c = 0; c < 200; c++) begin
      tick();
      seen = seen | ((quiesce_req | ~clk_en) & cfg_force_on);
    end
    check("force_on_never_gates", seen, 4'h0);
    check("unforced_gated", clk_en, 4'b0101);
    cfg_gate_en = 1'b0;
    tick();
    check("gate_off_clk_en", clk_en, 4'hF);
    check("gate_off_waking", dom_ready, 4'b0101);
    ticks(5);
    check("gate_off_ready", dom_ready, 4'hF);
    check("gate_off_req", quiesce_req, 4'h0);

    // asynchronous reset with two domains gated
    cfg_gate_en = 1'b1;
    ticks(20);
    check("pre_reset_gated", clk_en, 4'b0101);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_clk_en", clk_en, 4'hF);
    check("async_reset_ready", dom_ready, 4'hF);
    check("async_reset_req", quiesce_req, 4'h0);
    ticks(3);
    rst_n = 1'b1;

    // randomized traffic, checked by the scoreboard every cycle
    busy_pct = 6; wake_pct = 2; ack_pct = 30;
    for (int c = 0; c < 6000; c++) begin
      if (c % 300 == 0) begin
        cfg_idle_thresh = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
        cfg_gate_en     = ($urandom_range(0, 7) != 0);
        cfg_force_on    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        busy_pct        = ($urandom_range(0, 2) == 0) ? 0 : 6;
        wake_pct        = ($urandom_range(0, 1) == 0) ? 0 : 2;
        ack_pct         = ($urandom_range(0, 2) == 0) ? 0 : 30;
      end
      for (int d = 0; d < NDOM; d++) begin
        dom_busy[d]    = ($urandom_range(0, 99) < busy_pct);
        dom_wake[d]    = ($urandom_range(0, 99) < wake_pct);
        quiesce_ack[d] = ($urandom_range(0, 99) < ack_pct);
      end
      tick();
    end

    ticks(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mp64_clkgate_ctrl.md
# mp64_clkgate_ctrl

Per-domain clock-gating sequencer for the MP64 power-management path. It watches NDOM clock domains and gates any domain that stays idle past a programmable threshold. Gating is done with a quiesce request/acknowledge handshake, and a domain is ungated on any wake event, with a fixed settle interval before it is reported ready. Each `clk_en[i]` output drives the `enable` input of one `mp64_clkgate` instance. The controller runs on the ungated root clock.

## Interface
- `NDOM`, 4: number of gated domains (1..8).
- `IDLE_W`, 16: idle-counter and threshold width.
- `DRAIN_TMO`, 64: max cycles in DRAIN waiting for `quiesce_ack` (≥2).
- `WAKE_CYC`, 4: settle cycles after re-enabling a clock (≥1).

- `clk`  in  1: root clock, ungated.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cfg_gate_en`  in  1: global gating permit. 0 forces every domain to ungate.
- `cfg_idle_thresh`  in  IDLE_W: idle cycles before gating. 0 means never gate.
- `cfg_force_on`  in  NDOM: per-domain keep-alive. 1 means never gate that domain.
- `dom_busy`  in  NDOM: domain has work in flight.
- `dom_wake`  in  NDOM: wake request (interrupt, bus access).
- `quiesce_ack`  in  NDOM: domain is parked and safe to stop.
- `clk_en`  out  NDOM: enable to the `mp64_clkgate` instances.
- `quiesce_req`  out  NDOM: request the domain to park or stay parked.
- `dom_ready`  out  NDOM: domain clock is running and settled.
- `drain_tmo`  out  NDOM: one-cycle pulse when a drain times out.

## Operation
- Each domain has an independent 4-state FSM: RUN, DRAIN, GATED, WAKE.
- Each domain also has an IDLE_W-bit idle counter and a shared-width down-counter for DRAIN/WAKE timing.
- Define `allow[i] = cfg_gate_en & ~cfg_force_on[i] & (cfg_idle_thresh != 0)`.
- Define `act[i] = dom_busy[i] | dom_wake[i]`.
- RUN:
  - clk_en=1, quiesce_req=0, dom_ready=1.
  - If `act` or `~allow`, the idle counter clears to 0.
  - Otherwise it increments, saturating at all-ones.
  - When `allow` holds and the counter is ≥ `cfg_idle_thresh`, go to DRAIN. The ≥ compare means lowering the threshold mid-count takes effect immediately.
- DRAIN:
  - clk_en=1, quiesce_req=1, dom_ready=1.
  - Transitions in priority order:
    1. `act` or `~allow`: go to RUN, counter cleared.
    2. `quiesce_ack`: go to GATED.
    3. DRAIN_TMO cycles elapsed without ack: go to RUN, counter cleared, `drain_tmo` pulses for 1 cycle.
- GATED:
  - clk_en=0, quiesce_req=1, dom_ready=0.
  - On `act` or `~allow`, go to WAKE.
  - `quiesce_ack` is ignored in this state.
- WAKE:
  - clk_en=1, quiesce_req=1, dom_ready=0.
  - After WAKE_CYC cycles, go to RUN with the counter cleared.
  - WAKE always completes; `act` cannot shorten it.
  - If `allow` is still true, the counter restarts from 0 in RUN.
- Simultaneous events:
  - wake/busy together with ack in DRAIN: abort wins, clock stays on.
  - Timeout and ack in the same cycle: ack wins, go to GATED.
- Domains are fully independent. There is no global sequencing or staggering.

## Timing
- All outputs are registered. Outputs reflect the state after the clock edge on which the transition is taken.
- Reset values (asynchronous assert, synchronous to `clk` on deassert):
  - state RUN, counters 0
  - clk_en all 1, dom_ready all 1
  - quiesce_req all 0, drain_tmo all 0
- Latency, idle to request:
  - Counter reaches threshold T after T idle cycles.
  - `quiesce_req` rises on the next edge, so T+1 cycles after the last `act` cycle.
- Ack to gate: `quiesce_ack` high at edge k gives clk_en=0 after edge k.
- Wake to clock: `dom_wake` high at edge k gives clk_en=1 after edge k.
- Wake to ready: `dom_ready` returns after edge k+1+WAKE_CYC, and `quiesce_req` drops on the same edge.
- Timeout: `drain_tmo` pulses on the edge ending cycle DRAIN_TMO of DRAIN.
- Glitch safety: `clk_en` changes only on `clk` rising edges. The downstream ICG latches the enable during the low phase, so `clk_out` is glitch-free.
- Reset mid-operation: any state returns to RUN with clocks enabled immediately on `rst_n` falling, without waiting for a clock edge.

## Test plan
- Idle gating (thresh=10, one domain idle, ack tied high 2 cycles after req):
  - quiesce_req rises 11 cycles after busy drops.
  - clk_en falls the cycle after ack; dom_ready=0.
- Wake (WAKE_CYC=4, pulse dom_wake=1 for 1 cycle while GATED):
  - clk_en=1 the next cycle; dom_ready=1 and quiesce_req=0 exactly 5 cycles after the pulse edge.
  - Check that re-gating needs a fresh 10 idle cycles.
- Drain timeout (DRAIN_TMO=64, ack held low):
  - drain_tmo pulses once after 64 DRAIN cycles; FSM goes to RUN and clk_en never drops.
  - With inputs unchanged, a new drain starts 11 cycles later.
- Abort race: in DRAIN, assert dom_busy and quiesce_ack in the same cycle → RUN, clk_en stays 1, quiesce_req drops.
- Config overrides:
  - thresh=0 or force_on[i]=1: domain never gates over 1000 idle cycles.
  - Clearing cfg_gate_en while GATED → WAKE → RUN.
- Reset mid-GATED: drop rst_n asynchronously with 2 domains gated → clk_en=all 1, dom_ready=all 1, quiesce_req=0 before the next clk edge.
